// File: rtl/prod_block_sched.sv
// ---- prod_block_sched: round-robin scheduler sharing one Product_Block multiplier (rev 1.0) ----
// Grants one (w, x) job at a time, integrates pb_out into a saturating count, returns it with the requester ID.
`default_nettype none

module prod_block_sched #(
  parameter int NREQ = 4,
  parameter int OPW  = 4,
  parameter int CNTW = 8,
  parameter int TMO  = 64,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*OPW-1:0]  req_w,
  input  logic [NREQ*OPW-1:0]  req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic                 pb_in_rdy,
  output logic [OPW-1:0]       pb_w,
  output logic [OPW-1:0]       pb_x,
  input  logic                 pb_done,
  input  logic                 pb_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [CNTW-1:0]      rsp_count,
  output logic                 rsp_timeout,
  output logic                 busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int              WDW     = $clog2(TMO);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TMO - 1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam logic [IDW-1:0]  ID_LAST = IDW'(NREQ - 1);

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [WDW-1:0] wdog;
  logic           gnt_found;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] cand_idx;
  int             cand;

  // First asserted request at or after the round-robin pointer, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_idx = IDW'(cand);
      if (!gnt_found && req_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // The accept pulse must coincide with the grant decision so the requester can drop on the same edge.
  always_comb begin
    req_ready = '0;
    if (reset_n && state == S_IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pb_in_rdy   <= 1'b0;
      pb_w        <= '0;
      pb_x        <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_count   <= '0;
      rsp_timeout <= 1'b0;
      ptr         <= '0;
      wdog        <= '0;
    end else begin
      pb_in_rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            pb_w        <= req_w[int'(gnt_idx)*OPW +: OPW];
            pb_x        <= req_x[int'(gnt_idx)*OPW +: OPW];
            rsp_id      <= gnt_idx;
            rsp_count   <= '0;
            rsp_timeout <= 1'b0;
            wdog        <= '0;
            pb_in_rdy   <= 1'b1;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (pb_out && rsp_count != CNT_MAX) rsp_count <= rsp_count + 1'b1;
          wdog <= wdog + 1'b1;
          // Completion wins over a watchdog expiry in the same cycle.
          if (pb_done) begin
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end else if (wdog == WD_LAST) begin
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ptr       <= (rsp_id == ID_LAST) ? '0 : rsp_id + 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prod_block_sched.sv
// ---- tb_prod_block_sched: randomized self-checking bench for prod_block_sched (rev 1.0) ----
`default_nettype none

module tb_prod_block_sched;

  localparam int NREQ = 4;
  localparam int OPW  = 4;
  localparam int CNTW = 8;
  localparam int TMO  = 64;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*OPW-1:0] req_w;
  logic [NREQ*OPW-1:0] req_x;
  logic [NREQ-1:0]     req_ready;
  logic                pb_in_rdy;
  logic [OPW-1:0]      pb_w;
  logic [OPW-1:0]      pb_x;
  logic                pb_done;
  logic                pb_out;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [CNTW-1:0]     rsp_count;
  logic                rsp_timeout;
  logic                busy;

  prod_block_sched #(.NREQ(NREQ), .OPW(OPW), .CNTW(CNTW), .TMO(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_w(req_w), .req_x(req_x), .req_ready(req_ready),
    .pb_in_rdy(pb_in_rdy), .pb_w(pb_w), .pb_x(pb_x),
    .pb_done(pb_done), .pb_out(pb_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_count(rsp_count), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; int cyc; int a; int b; } ev_t;
  ev_t grants[$];
  ev_t launches[$];
  ev_t resps[$];

  int              pulse_cfg [NREQ];
  int              extra_cfg [NREQ];
  int              cur_pulses = -1;
  int              cur_extra  = 0;
  logic [NREQ-1:0] cont;
  bit              rnd_stall;
  int              checks   = 0;
  int              failures = 0;

  // Event monitor plus requester behaviour: a granted requester drops its request after the accept edge.
  initial begin
    ev_t             e;
    logic [NREQ-1:0] drop;
    int              gi;
    forever begin
      @(negedge clk);
      drop = '0;
      if (reset_n === 1'b1) begin
        if (req_ready != '0) begin
          gi = 0;
          for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
          e.id = gi; e.cyc = cyc; e.a = $countones(req_ready); e.b = 0;
          grants.push_back(e);
          drop       = req_ready & ~cont;
          cur_pulses = pulse_cfg[gi];
          cur_extra  = extra_cfg[gi];
        end
        if (pb_in_rdy) begin
          e.id = 0; e.cyc = cyc; e.a = int'(pb_w); e.b = int'(pb_x);
          launches.push_back(e);
        end
        if (rsp_valid && rsp_ready) begin
          e.id = int'(rsp_id); e.cyc = cyc; e.a = int'(rsp_count); e.b = int'(rsp_timeout);
          resps.push_back(e);
        end
      end
      @(posedge clk);
      #1;
      req_valid = req_valid & ~drop;
      if (rnd_stall) rsp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Product_Block model: P = w*x pulses, then E idle cycles, then pb_done; E < 0 means it never finishes.
  initial begin
    int left;
    int ext;
    bit active;
    active = 1'b0; left = 0; ext = 0;
    pb_out = 1'b0; pb_done = 1'b0;
    forever begin
      @(negedge clk);
      pb_out  = 1'b0;
      pb_done = 1'b0;
      if (reset_n !== 1'b1) begin
        active = 1'b0;
      end else if (pb_in_rdy) begin
        active = 1'b1;
        left   = (cur_pulses >= 0) ? cur_pulses : int'(pb_w) * int'(pb_x);
        ext    = cur_extra;
      end else if (active) begin
        if (left > 0) begin
          pb_out = 1'b1;
          left   = left - 1;
        end else if (ext > 0) begin
          ext = ext - 1;
        end else if (ext == 0) begin
          pb_done = 1'b1;
          active  = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, got cyc=%0d required < 50000", cyc);
    $fatal(1);
  end

  function automatic void model_job(input int p, input int e, output int cnt, output int tmo);
    if (e >= 0 && p + e <= TMO - 1) begin
      cnt = p; tmo = 0;
    end else begin
      cnt = (p < TMO) ? p : TMO; tmo = 1;
    end
    if (cnt > (1 << CNTW) - 1) cnt = (1 << CNTW) - 1;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] pend, input int ptr);
    for (int k = 0; k < NREQ; k++) if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic clear_q();
    grants.delete(); launches.delete(); resps.delete();
  endtask

  task automatic default_cfg();
    for (int i = 0; i < NREQ; i++) begin pulse_cfg[i] = -1; extra_cfg[i] = 0; end
  endtask

  task automatic set_op(input int i, input int w, input int x);
    req_w[i*OPW +: OPW] = OPW'(w);
    req_x[i*OPW +: OPW] = OPW'(x);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    clear_q();
    default_cfg();
  endtask

  task automatic wait_resps(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (resps.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_grants(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk);
      if (grants.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    reset_n   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, pb_in_rdy, pb_w, pb_x, rsp_valid, rsp_id, rsp_count, rsp_timeout, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got req_ready=%b pb_in_rdy=%b pb_w=%0d pb_x=%0d rsp_valid=%b rsp_id=%0d rsp_count=%0d rsp_timeout=%b busy=%b required all zero",
               req_ready, pb_in_rdy, pb_w, pb_x, rsp_valid, rsp_id, rsp_count, rsp_timeout, busy);
    end
    req_valid = '0;
    @(posedge clk); #2;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, req_ready, rsp_valid} !== '0) begin
      failures++;
      $display("FAIL reset_idle: got busy=%b req_ready=%b rsp_valid=%b required 0/0000/0", busy, req_ready, rsp_valid);
    end
  endtask

  task automatic test_single();
    bit ok;
    clear_q(); default_cfg();
    @(posedge clk); #2;
    set_op(0, 2, 3);
    req_valid[0] = 1'b1;
    wait_resps(1, 200, ok);
    checks++;
    if (!ok || grants.size() != 1 || launches.size() != 1) begin
      failures++;
      $display("FAIL single_events: got resps=%0d grants=%0d launches=%0d required 1/1/1", resps.size(), grants.size(), launches.size());
    end else begin
      checks++;
      if (grants[0].id !== 0 || grants[0].a !== 1) begin
        failures++;
        $display("FAIL single_grant: got id=%0d ones=%0d required id=0 ones=1", grants[0].id, grants[0].a);
      end
      checks++;
      if (launches[0].cyc - grants[0].cyc !== 1 || launches[0].a !== 2 || launches[0].b !== 3) begin
        failures++;
        $display("FAIL single_launch: got lat=%0d w=%0d x=%0d required lat=1 w=2 x=3",
                 launches[0].cyc - grants[0].cyc, launches[0].a, launches[0].b);
      end
      checks++;
      if (resps[0].id !== 0 || resps[0].a !== 6 || resps[0].b !== 0 || resps[0].cyc - grants[0].cyc !== 9) begin
        failures++;
        $display("FAIL single_resp: got id=%0d count=%0d tmo=%0d lat=%0d required id=0 count=6 tmo=0 lat=9",
                 resps[0].id, resps[0].a, resps[0].b, resps[0].cyc - grants[0].cyc);
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_id  [5] = '{0, 1, 2, 3, 0};
    int exp_cnt [5] = '{1, 4, 15, 16, 1};
    do_reset();
    set_op(0, 1, 1); set_op(1, 2, 2); set_op(2, 3, 5); set_op(3, 4, 4);
    @(posedge clk); #2;
    cont = '1;
    req_valid = '1;
    wait_grants(5, 500, ok);
    @(posedge clk); #2;
    req_valid = '0;
    cont = '0;
    wait_resps(5, 500, ok);
    checks++;
    if (!ok || grants.size() < 5) begin
      failures++;
      $display("FAIL rr_events: got resps=%0d grants=%0d required 5/5", resps.size(), grants.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (grants[k].id !== exp_id[k] || resps[k].id !== exp_id[k] || resps[k].a !== exp_cnt[k] || resps[k].b !== 0) begin
          failures++;
          $display("FAIL rr_job%0d: got grant=%0d rsp_id=%0d count=%0d tmo=%0d required id=%0d count=%0d tmo=0",
                   k, grants[k].id, resps[k].id, resps[k].a, resps[k].b, exp_id[k], exp_cnt[k]);
        end
      end
    end
  endtask

  task automatic test_zero_operand();
    bit ok;
    clear_q(); default_cfg();
    @(posedge clk); #2;
    set_op(3, 0, 9);
    req_valid[3] = 1'b1;
    wait_resps(1, 100, ok);
    @(negedge clk);
    checks++;
    if (!ok || grants.size() != 1 || launches.size() != 1) begin
      failures++;
      $display("FAIL zero_events: got resps=%0d grants=%0d required 1/1", resps.size(), grants.size());
    end else begin
      checks++;
      if (resps[0].id !== 3 || resps[0].a !== 0 || resps[0].b !== 0 || launches[0].a !== 0 || launches[0].b !== 9) begin
        failures++;
        $display("FAIL zero_resp: got id=%0d count=%0d tmo=%0d w=%0d x=%0d required 3/0/0/0/9",
                 resps[0].id, resps[0].a, resps[0].b, launches[0].a, launches[0].b);
      end
      checks++;
      if (resps[0].cyc - grants[0].cyc !== 3 || busy !== 1'b0) begin
        failures++;
        $display("FAIL zero_latency: got grant_to_resp=%0d busy_after=%b required 3 and 0", resps[0].cyc - grants[0].cyc, busy);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_q(); default_cfg();
    pulse_cfg[0] = 3;
    extra_cfg[0] = -1;
    @(posedge clk); #2;
    set_op(0, 5, 5);
    req_valid[0] = 1'b1;
    wait_resps(1, 300, ok);
    checks++;
    if (!ok || grants.size() != 1) begin
      failures++;
      $display("FAIL timeout_events: got resps=%0d grants=%0d required 1/1", resps.size(), grants.size());
    end else begin
      checks++;
      if (resps[0].id !== 0 || resps[0].a !== 3 || resps[0].b !== 1 || resps[0].cyc - grants[0].cyc !== 2 + TMO) begin
        failures++;
        $display("FAIL timeout_resp: got id=%0d count=%0d tmo=%0d lat=%0d required 0/3/1/%0d",
                 resps[0].id, resps[0].a, resps[0].b, resps[0].cyc - grants[0].cyc, 2 + TMO);
      end
    end
    clear_q(); default_cfg();
    @(posedge clk); #2;
    set_op(1, 2, 2);
    req_valid[1] = 1'b1;
    wait_resps(1, 200, ok);
    checks++;
    if (!ok || resps[0].id !== 1 || resps[0].a !== 4 || resps[0].b !== 0) begin
      failures++;
      $display("FAIL timeout_recover: got ok=%0d id=%0d count=%0d tmo=%0d required 1/1/4/0",
               ok, ok ? resps[0].id : -1, ok ? resps[0].a : -1, ok ? resps[0].b : -1);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int exp_id  [3] = '{2, 3, 1};
    int exp_cnt [3] = '{9, 6, 2};
    clear_q(); default_cfg();
    @(posedge clk); #2;
    rsp_ready = 1'b0;
    set_op(2, 3, 3);
    req_valid[2] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rsp_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_rsp_valid: got rsp_valid=%b required 1 within 200 cycles", rsp_valid);
    end
    set_op(1, 1, 2); set_op(3, 2, 3);
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_id, rsp_count, rsp_timeout, req_ready} !== {1'b1, 2'd2, 8'd9, 1'b0, 4'b0000}) begin
        failures++;
        $display("FAIL bp_hold%0d: got valid=%b id=%0d count=%0d tmo=%b req_ready=%b required 1/2/9/0/0000",
                 k, rsp_valid, rsp_id, rsp_count, rsp_timeout, req_ready);
      end
    end
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    wait_resps(3, 600, ok);
    checks++;
    if (!ok || grants.size() < 3) begin
      failures++;
      $display("FAIL bp_events: got resps=%0d grants=%0d required 3/3", resps.size(), grants.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (grants[k].id !== exp_id[k] || resps[k].id !== exp_id[k] || resps[k].a !== exp_cnt[k]) begin
          failures++;
          $display("FAIL bp_job%0d: got grant=%0d rsp_id=%0d count=%0d required id=%0d count=%0d",
                   k, grants[k].id, resps[k].id, resps[k].a, exp_id[k], exp_cnt[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit ok;
    int np;
    clear_q(); default_cfg();
    @(posedge clk); #2;
    set_op(2, 1, 1);
    req_valid[2] = 1'b1;
    wait_resps(1, 100, ok);
    clear_q();
    @(posedge clk); #2;
    set_op(3, 3, 3);
    req_valid[3] = 1'b1;
    ok = 1'b0;
    np = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk);
      if (launches.size() > 0 && pb_out) np++;
      if (np == 2) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL rst_mid_pulses: got %0d pulses required 2 within 60 cycles", np);
    end
    #1;
    reset_n = 1'b0;
    req_valid = '0;
    clear_q();
    #1;
    checks++;
    if ({req_ready, pb_in_rdy, pb_w, pb_x, rsp_valid, rsp_id, rsp_count, rsp_timeout, busy} !== '0) begin
      failures++;
      $display("FAIL rst_mid_outputs: got pb_in_rdy=%b pb_w=%0d pb_x=%0d rsp_valid=%b rsp_id=%0d rsp_count=%0d rsp_timeout=%b busy=%b required all zero",
               pb_in_rdy, pb_w, pb_x, rsp_valid, rsp_id, rsp_count, rsp_timeout, busy);
    end
    set_op(2, 2, 5); set_op(3, 1, 7);
    req_valid = 4'b1100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid_ready: got req_ready=%b required 0000 while in reset", req_ready);
    end
    @(posedge clk); #2;
    reset_n = 1'b1;
    wait_resps(2, 300, ok);
    checks++;
    if (!ok || grants.size() < 2) begin
      failures++;
      $display("FAIL rst_mid_events: got resps=%0d grants=%0d required 2/2", resps.size(), grants.size());
    end else begin
      checks++;
      if (grants[0].id !== 2 || resps[0].id !== 2 || resps[0].a !== 10 || resps[0].b !== 0) begin
        failures++;
        $display("FAIL rst_mid_first: got grant=%0d rsp_id=%0d count=%0d tmo=%0d required 2/2/10/0",
                 grants[0].id, resps[0].id, resps[0].a, resps[0].b);
      end
      checks++;
      if (grants[1].id !== 3 || resps[1].id !== 3 || resps[1].a !== 7) begin
        failures++;
        $display("FAIL rst_mid_second: got grant=%0d rsp_id=%0d count=%0d required 3/3/7", grants[1].id, resps[1].id, resps[1].a);
      end
    end
  endtask

  task automatic test_random();
    bit              ok;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] pend;
    int              mptr;
    int              w, x, r, c, n;
    int              opp [NREQ];
    int              exp_id[$], exp_cnt[$], exp_tmo[$];
    int              ec, et;
    do_reset();
    mptr = 0;
    rnd_stall = 1'b1;
    for (int b = 0; b < 12; b++) begin
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      exp_id.delete(); exp_cnt.delete(); exp_tmo.delete();
      for (int i = 0; i < NREQ; i++) begin
        w = $urandom_range(0, 15);
        x = $urandom_range(0, 15);
        set_op(i, w, x);
        opp[i] = w * x;
        pulse_cfg[i] = -1;
        r = $urandom_range(0, 7);
        if (r == 0)      extra_cfg[i] = TMO - 1 - opp[i] + $urandom_range(0, 2) - 1;
        else if (r == 1) extra_cfg[i] = -1;
        else             extra_cfg[i] = $urandom_range(0, 4);
        if (r == 0 && extra_cfg[i] < 0) extra_cfg[i] = 0;
      end
      pend = mask;
      while (pend != '0) begin
        c = rr_pick(pend, mptr);
        model_job(opp[c], extra_cfg[c], ec, et);
        exp_id.push_back(c); exp_cnt.push_back(ec); exp_tmo.push_back(et);
        pend[c] = 1'b0;
        mptr = (c + 1) % NREQ;
      end
      n = exp_id.size();
      clear_q();
      @(posedge clk); #2;
      req_valid = mask;
      wait_resps(n, 2000, ok);
      checks++;
      if (!ok || grants.size() < n) begin
        failures++;
        $display("FAIL rand_b%0d_events: got resps=%0d grants=%0d required %0d", b, resps.size(), grants.size(), n);
      end else begin
        for (int k = 0; k < n; k++) begin
          checks++;
          if (grants[k].id !== exp_id[k] || resps[k].id !== exp_id[k] || resps[k].a !== exp_cnt[k] || resps[k].b !== exp_tmo[k]) begin
            failures++;
            $display("FAIL rand_b%0d_j%0d: got grant=%0d rsp_id=%0d count=%0d tmo=%0d required id=%0d count=%0d tmo=%0d",
                     b, k, grants[k].id, resps[k].id, resps[k].a, resps[k].b, exp_id[k], exp_cnt[k], exp_tmo[k]);
          end
        end
      end
      @(posedge clk); #2;
    end
    rnd_stall = 1'b0;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_w     = '0;
    req_x     = '0;
    rsp_ready = 1'b1;
    cont      = '0;
    rnd_stall = 1'b0;
    default_cfg();
    test_reset();
    test_single();
    test_round_robin();
    test_zero_operand();
    test_timeout();
    test_backpressure();
    test_reset_mid_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prod_block_sched.md
Name: prod_block_sched

Overview:
- Round-robin scheduler that shares one Product_Block multiplier among NREQ requesters.
- Accepts a (w, x) operand pair from one requester at a time and launches it with a one-cycle pb_in_rdy pulse.
- Integrates the multiplier's 1-bit pb_out stream into a pulse count until pb_done.
- Returns the count with the requester ID over a valid/ready response channel; a watchdog timeout guards against a hung multiplier.

Parameters:
- NREQ, 4, number of requesters (2..16).
- OPW, 4, operand width of w and x; matches Product_Block.
- CNTW, 8, width of the result pulse counter; saturates at 2^CNTW-1.
- TMO, 64, maximum WAIT cycles before the job is aborted as timed out (>=2).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester request pending.
- req_w  in  NREQ*OPW  packed w operands; requester i at [i*OPW +: OPW].
- req_x  in  NREQ*OPW  packed x operands; same packing.
- req_ready  out  NREQ  one-hot, one-cycle accept pulse to the granted requester.
- pb_in_rdy  out  1  launch strobe to Product_Block.
- pb_w  out  OPW  w operand to Product_Block.
- pb_x  out  OPW  x operand to Product_Block.
- pb_done  in  1  Product_Block completion.
- pb_out  in  1  Product_Block output pulse stream.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  $clog2(NREQ)  requester index of the response.
- rsp_count  out  CNTW  number of cycles pb_out was high during the job.
- rsp_timeout  out  1  job ended by watchdog rather than pb_done.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; req_ready=0; pb_in_rdy=0; pb_w=pb_x=0; rsp_valid=0; rsp_id=0; rsp_count=0; rsp_timeout=0; busy=0; RR pointer=0; counters=0.
- Reset asserted mid-job abandons the job with no response. Product_Block shares reset_n, so it is cleared at the same time.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, grant the first asserted index at or after the RR pointer, wrapping modulo NREQ.
  - Latch that requester's w and x into pb_w/pb_x, latch its ID, pulse req_ready[id] for this cycle only.
  - Clear the count and watchdog, then go to ISSUE.
  - Requesters must hold req_valid and operands stable until they see req_ready.
- ISSUE: pb_in_rdy=1 for exactly one cycle, with pb_w/pb_x valid. Go to WAIT.
  - pb_w/pb_x hold their latched values from ISSUE through the end of WAIT.
- WAIT:
  - Every cycle pb_out=1 increments the count, saturating at 2^CNTW-1 with no wrap.
  - The watchdog increments every cycle.
  - On pb_done=1: go to RESP with rsp_timeout=0. pb_out in the same cycle as pb_done is counted.
  - If the watchdog reaches TMO-1 without pb_done: go to RESP with rsp_timeout=1; the count so far is reported.
  - pb_done and the timeout in the same cycle resolve as done (timeout=0).
  - pb_done or pb_out outside WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_count and rsp_timeout are stable until rsp_ready.
  - On rsp_valid && rsp_ready: rsp_valid drops next cycle, RR pointer becomes (id+1) mod NREQ, go to IDLE.
- Latency:
  - Grant to pb_in_rdy: 1 cycle.
  - pb_done to rsp_valid: 1 cycle.
  - Minimum job (pb_done in the first WAIT cycle, rsp_ready held high): 4 cycles from grant to return to IDLE.
- Only one job is in flight at a time; no new grant is issued until RESP completes.
- Fairness: a continuously requesting index waits at most NREQ-1 jobs.

Test Plan:
- Single job: reset, requester 0 sends w=2, x=3; the bench Product_Block model emits 6 pb_out pulses then pb_done -> req_ready[0] one cycle, pb_in_rdy 1 cycle later with pb_w=2, pb_x=3; then rsp_valid, rsp_id=0, rsp_count=6, rsp_timeout=0.
- Round robin: all 4 requesters valid continuously, with operands (1,1), (2,2), (3,5), (4,4) -> grant order 0,1,2,3,0; counts 1, 4, 15, 16.
- Zero operand: w=0, x=9; model asserts pb_done in the first WAIT cycle with no pulses -> rsp_count=0; grant to IDLE takes 4 cycles.
- Timeout: model emits 3 pulses and never asserts pb_done -> after 64 WAIT cycles rsp_timeout=1, rsp_count=3; the next request is served normally.
- Backpressure: rsp_ready held low 10 cycles -> rsp_valid and all rsp fields stable, no new req_ready while held; the RR pointer advances only after the handshake.
- Reset mid-WAIT: assert reset_n=0 after 2 pulses -> all outputs return to reset values immediately; after release, requester 2 alone is granted first, because the pointer is 0 and index 2 is the first asserted.
